// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the single-port SoC SRAM, bounded-burst fairness.
// Ports: req/gnt/addr/we/wdata/strb per requester, rvalid/rdata back, mem_* to SRAM.
module sram_port_arbiter #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned StrbWidth = DataWidth / 8,
    parameter int unsigned MaxBurst  = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [1:0]                     req_i,
    output logic [1:0]                     gnt_o,
    input  logic [1:0][AddrWidth-1:0]      addr_i,
    input  logic [1:0]                     we_i,
    input  logic [1:0][DataWidth-1:0]      wdata_i,
    input  logic [1:0][StrbWidth-1:0]      strb_i,
    output logic [1:0]                     rvalid_o,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [AddrWidth-1:0]           mem_addr_o,
    output logic [DataWidth-1:0]           mem_wdata_o,
    output logic [DataWidth-1:0]           mem_wmask_o,
    input  logic [DataWidth-1:0]           mem_rdata_i,
    output logic [31:0]                    contention_cnt_o
);

    localparam int unsigned BurstW = $clog2(MaxBurst + 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);

    logic              owner_q, owner_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [31:0]       cnt_q, cnt_d;

    logic gnt_any;
    logic gnt_sel;
    logic oth_req;

    // Grant select: lone requester wins; on contention the owner keeps the
    // port until it has used up its burst allowance.
    always_comb begin
        gnt_any = |req_i;
        gnt_sel = 1'b0;
        unique case (req_i)
            2'b10:   gnt_sel = 1'b1;
            2'b11:   gnt_sel = (burst_q < BurstMax) ? owner_q : ~owner_q;
            default: gnt_sel = 1'b0;
        endcase
        gnt_o = gnt_any ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
    end

    always_comb begin
        mem_req_o   = gnt_any;
        mem_we_o    = gnt_any & we_i[gnt_sel];
        mem_addr_o  = gnt_any ? addr_i[gnt_sel] : '0;
        mem_wdata_o = gnt_any ? wdata_i[gnt_sel] : '0;
        mem_wmask_o = '0;
        for (int b = 0; b < int'(StrbWidth); b++) begin
            mem_wmask_o[b*8 +: 8] = {8{gnt_any & strb_i[gnt_sel][b]}};
        end
    end

    always_comb begin
        oth_req = req_i[~gnt_sel];
        owner_d = owner_q;
        burst_d = burst_q;
        if (gnt_any) begin
            if (gnt_sel == owner_q) begin
                if (!oth_req)
                    burst_d = '0;
                else if (burst_q < BurstMax)
                    burst_d = burst_q + 1'b1;
                else
                    burst_d = BurstMax;
            end else begin
                owner_d = gnt_sel;
                burst_d = oth_req ? BurstW'(1) : '0;
            end
        end
        // Only reads get a response; writes retire at the grant edge.
        rvalid_d = gnt_o & ~{2{mem_we_o}};
        cnt_d    = cnt_q;
        if (req_i == 2'b11 && cnt_q != '1)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= 1'b0;
            burst_q  <= '0;
            rvalid_q <= 2'b00;
            cnt_q    <= '0;
        end else begin
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            rvalid_q <= rvalid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rvalid_o         = rvalid_q;
    assign rdata_o          = mem_rdata_i;
    assign contention_cnt_o = cnt_q;

endmodule
